// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserializer plus AA55-delimited
// frame parser producing battery voltage, current and torque.
module telemetry_rx #(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_CYCLES);
  localparam logic [CW-1:0] HALF = CW'(BAUD_CYCLES / 2);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    HUNT, SYNC, B_H, B_L, C_H, C_L, T_H, T_L
  } ps_st_t;

  logic          rx_s1_q, rx_s2_q, rx_p_q;
  rx_st_t        rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rdy_q, rdy_d;
  logic          sbad;
  logic          fall, samp;

  ps_st_t        ps_q, ps_d;
  logic [3:0]    bh_q, bh_d, ch_q, ch_d, th_q, th_d;
  logic [7:0]    bl_q, bl_d, cl_q, cl_d;
  logic [11:0]   bv_q, bv_d, cu_q, cu_d, tq_q, tq_d;
  logic          pkt_q, pkt_d;
  logic          err_q, err_d;
  logic          nib_err;

  assign fall = rx_p_q & ~rx_s2_q;
  assign samp = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q  <= 1'b1;
      rs_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_p_q  <= rx_s2_q;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    rs_d  = rs_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    rdy_d = 1'b0;
    sbad  = 1'b0;
    if (rs_q != R_IDLE && !samp)
      cnt_d = cnt_q - CW'(1);
    unique case (rs_q)
      R_IDLE: begin
        if (fall) begin
          cnt_d = HALF;
          rs_d  = R_START;
        end
      end
      R_START: begin
        if (samp) begin
          if (rx_s2_q) begin
            rs_d = R_IDLE;
          end else begin
            cnt_d = FULL;
            bit_d = '0;
            rs_d  = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (samp) begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          cnt_d = FULL;
          if (bit_q == 4'd7) begin
            bit_d = '0;
            rs_d  = R_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      R_STOP: begin
        if (samp) begin
          rs_d  = R_IDLE;
          rdy_d = rx_s2_q;
          sbad  = ~rx_s2_q;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q  <= HUNT;
      bh_q  <= '0;
      bl_q  <= '0;
      ch_q  <= '0;
      cl_q  <= '0;
      th_q  <= '0;
      bv_q  <= '0;
      cu_q  <= '0;
      tq_q  <= '0;
      pkt_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      bh_q  <= bh_d;
      bl_q  <= bl_d;
      ch_q  <= ch_d;
      cl_q  <= cl_d;
      th_q  <= th_d;
      bv_q  <= bv_d;
      cu_q  <= cu_d;
      tq_q  <= tq_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
    end
  end

  // High nibble bytes must carry a zero upper nibble.
  always_comb begin
    ps_d    = ps_q;
    bh_d    = bh_q;
    bl_d    = bl_q;
    ch_d    = ch_q;
    cl_d    = cl_q;
    th_d    = th_q;
    bv_d    = bv_q;
    cu_d    = cu_q;
    tq_d    = tq_q;
    pkt_d   = 1'b0;
    nib_err = 1'b0;
    if (sbad) begin
      ps_d = HUNT;
    end else if (rdy_q) begin
      unique case (ps_q)
        HUNT: if (sh_q == 8'hAA) ps_d = SYNC;
        SYNC: begin
          if (sh_q == 8'h55)      ps_d = B_H;
          else if (sh_q != 8'hAA) ps_d = HUNT;
        end
        B_H, C_H, T_H: begin
          if (sh_q[7:4] != 4'h0) begin
            nib_err = 1'b1;
            ps_d    = HUNT;
          end else begin
            if (ps_q == B_H) begin
              bh_d = sh_q[3:0];
              ps_d = B_L;
            end else if (ps_q == C_H) begin
              ch_d = sh_q[3:0];
              ps_d = C_L;
            end else begin
              th_d = sh_q[3:0];
              ps_d = T_L;
            end
          end
        end
        B_L: begin
          bl_d = sh_q;
          ps_d = C_H;
        end
        C_L: begin
          cl_d = sh_q;
          ps_d = T_H;
        end
        T_L: begin
          bv_d  = {bh_q, bl_q};
          cu_d  = {ch_q, cl_q};
          tq_d  = {th_q, sh_q};
          pkt_d = 1'b1;
          ps_d  = HUNT;
        end
        default: ps_d = HUNT;
      endcase
    end
    err_d = sbad | nib_err;
  end

  assign batt_v     = bv_q;
  assign avg_curr   = cu_q;
  assign avg_torque = tq_q;
  assign pkt_vld    = pkt_q;
  assign frm_err    = err_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Scoreboard bench for telemetry_rx: directed frames, errors,
// glitch rejection and mid-frame reset.
module tb_telemetry_rx;

  localparam int BC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, frm_err;

  typedef struct packed {
    logic        err;
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
  } ev_t;

  ev_t  q[$];
  ev_t  e;
  int   checks = 0;
  int   errors = 0;
  logic pv_prev = 1'b0;
  logic [11:0] lb, lc, lt;

  telemetry_rx #(.BAUD_CYCLES(BC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RX(rx),
    .batt_v(batt_v),
    .avg_curr(avg_curr),
    .avg_torque(avg_torque),
    .pkt_vld(pkt_vld),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_vld || frm_err) begin
      checks++;
      if (pkt_vld && frm_err) begin
        errors++;
        $display("FAIL both: pkt_vld=1 frm_err=1, required exclusive");
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: pkt_vld=%0b frm_err=%0b, none queued",
                 pkt_vld, frm_err);
      end else begin
        e = q.pop_front();
        if (e.err != frm_err ||
            (!e.err && {batt_v, avg_curr, avg_torque} != {e.b, e.c, e.t})) begin
          errors++;
          $display("FAIL event: got err=%0b %h/%h/%h, required err=%0b %h/%h/%h",
                   frm_err, batt_v, avg_curr, avg_torque,
                   e.err, e.b, e.c, e.t);
        end
      end
    end
    if (pkt_vld) begin
      checks++;
      if (pv_prev) begin
        errors++;
        $display("FAIL pulse: pkt_vld high 2 cycles, required 1");
      end
    end
    pv_prev = pkt_vld;
  end

  task automatic bitp(input logic v);
    rx = v;
    repeat (BC) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stp = 1'b1);
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(b[i]);
    bitp(stp);
  endtask

  task automatic push_pkt(input logic [11:0] b, c, t);
    ev_t x;
    x.err = 1'b0; x.b = b; x.c = c; x.t = t;
    q.push_back(x);
  endtask

  task automatic push_err();
    ev_t x;
    x = '0;
    x.err = 1'b1;
    q.push_back(x);
  endtask

  task automatic send_frame(input logic [11:0] b, c, t);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte({4'h0, b[11:8]});
    send_byte(b[7:0]);
    send_byte({4'h0, c[11:8]});
    send_byte(c[7:0]);
    send_byte({4'h0, t[11:8]});
    send_byte(t[7:0]);
  endtask

  task automatic chk(input string n, input logic [11:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  task automatic chk_outs(input string n);
    @(negedge clk);
    chk({n, "_batt"}, batt_v, lb);
    chk({n, "_curr"}, avg_curr, lc);
    chk({n, "_torq"}, avg_torque, lt);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events pending, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    lb = '0; lc = '0; lt = '0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pkt", {11'd0, pkt_vld}, 12'd0);
    chk("rst_err", {11'd0, frm_err}, 12'd0);
    chk_outs("rst");
    repeat (2 * BC) @(posedge clk);

    push_pkt(12'hB12, 12'h345, 12'h789);
    send_frame(12'hB12, 12'h345, 12'h789);
    push_pkt(12'hFFF, 12'h000, 12'hABC);
    send_frame(12'hFFF, 12'h000, 12'hABC);
    drain();
    lb = 12'hFFF; lc = 12'h000; lt = 12'hABC;
    chk_outs("two");

    push_pkt(12'h123, 12'h456, 12'h789);
    send_byte(8'h13);
    send_byte(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h01); send_byte(8'h23);
    send_byte(8'h04); send_byte(8'h56);
    send_byte(8'h07); send_byte(8'h89);
    drain();
    lb = 12'h123; lc = 12'h456; lt = 12'h789;
    chk_outs("resync");

    push_err();
    send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h0B); send_byte(8'h12);
    send_byte(8'h13); send_byte(8'h45);
    send_byte(8'h07); send_byte(8'h89);
    drain();
    chk_outs("nibble");
    push_pkt(12'hAAA, 12'h555, 12'h001);
    send_frame(12'hAAA, 12'h555, 12'h001);
    drain();
    lb = 12'hAAA; lc = 12'h555; lt = 12'h001;
    chk_outs("after_nib");

    push_err();
    send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h0B, 1'b0);
    bitp(1'b1); bitp(1'b1);
    send_byte(8'h12); send_byte(8'h03);
    send_byte(8'h45); send_byte(8'h07);
    send_byte(8'h89);
    drain();
    chk_outs("stop");

    rx = 1'b0;
    repeat (BC / 4) @(posedge clk);
    rx = 1'b1;
    repeat (3 * BC) @(posedge clk);
    drain();
    chk_outs("glitch");

    send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h0C); send_byte(8'h34);
    bitp(1'b0); bitp(1'b1);
    rx = 1'b0;
    repeat (BC / 2) @(posedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (12 * BC) @(posedge clk);
    lb = '0; lc = '0; lt = '0;
    chk_outs("midrst");

    push_pkt(12'h0C3, 12'h5A6, 12'hF00);
    send_frame(12'h0C3, 12'h5A6, 12'hF00);
    drain();
    lb = 12'h0C3; lc = 12'h5A6; lt = 12'hF00;
    chk_outs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
